// File: rtl/edge_row_reader_pkg.sv
// Shared widths and FSM encoding for the edge-cache row reader.
// Defaults match the Dijkstra datapath: 32 nodes, 5-bit index, 16-bit weights.
package edge_row_reader_pkg;

    localparam int DEFAULT_MAX_NODES   = 32;
    localparam int DEFAULT_INDEX_WIDTH = 5;
    localparam int DEFAULT_VALUE_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/edge_row_reader.sv
// Scans one adjacency row through the edge cache and streams present edges.
// Optional: EDGE_READER_SKIP_SELF_EN skips the column equal to the source node.
module edge_row_reader
    import edge_row_reader_pkg::*;
#(
    parameter int MAX_NODES   = DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
    parameter logic [VALUE_WIDTH-1:0] NO_EDGE = {VALUE_WIDTH{1'b1}}
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [INDEX_WIDTH-1:0] node,
    input  logic [INDEX_WIDTH:0]   num_nodes,
    output logic                   busy,
    output logic                   done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INDEX_WIDTH-1:0] out_to_node,
    output logic [VALUE_WIDTH-1:0] out_weight,
    output logic [INDEX_WIDTH-1:0] cache_from_node,
    output logic [INDEX_WIDTH-1:0] cache_to_node,
    output logic                   cache_read_enable,
    input  logic                   cache_ready,
    input  logic [VALUE_WIDTH-1:0] cache_edge_value
);

    localparam int CW = INDEX_WIDTH + 1;
    localparam logic [CW-1:0] MAX_N = CW'(MAX_NODES);

    state_t state, state_next;

    logic [CW-1:0] col;
    logic [CW-1:0] n_q;
    logic [CW-1:0] n_start;
    logic [CW-1:0] n_src;
    logic [CW-1:0] base;
    logic [CW-1:0] cand;
    logic          skip;
    logic          last;
    logic          advance;

    assign n_start = (num_nodes > MAX_N) ? MAX_N : num_nodes;

    // cand is the next column to visit; last means no such column exists.
`ifdef EDGE_READER_SKIP_SELF_EN
    logic [INDEX_WIDTH-1:0] node_src;
    assign node_src = (state == ST_IDLE) ? node : cache_from_node;
    assign skip = (base == {1'b0, node_src});
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        n_src = (state == ST_IDLE) ? n_start : n_q;
        base  = (state == ST_IDLE) ? '0 : col + CW'(1);
        cand  = base + CW'(skip);
        last  = (cand >= n_src);
    end

    always_comb begin
        state_next = state;
        advance    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = last ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (cache_ready) begin
                    if (cache_edge_value == NO_EDGE) begin
                        advance    = 1'b1;
                        state_next = last ? ST_DONE : ST_ISSUE;
                    end else begin
                        state_next = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    advance    = 1'b1;
                    state_next = last ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy              = (state != ST_IDLE);
    assign done              = (state == ST_DONE);
    assign out_valid         = (state == ST_EMIT);
    assign cache_read_enable = (state == ST_ISSUE);
    assign cache_to_node     = col[INDEX_WIDTH-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col             <= '0;
            n_q             <= '0;
            cache_from_node <= '0;
            out_to_node     <= '0;
            out_weight      <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                cache_from_node <= node;
                n_q             <= n_start;
                col             <= last ? '0 : cand;
            end
            if (state == ST_WAIT && cache_ready) begin
                out_weight  <= cache_edge_value;
                out_to_node <= col[INDEX_WIDTH-1:0];
            end
            // Counter stops on the last column so it never wraps.
            if (advance && !last) begin
                col <= cand;
            end
        end
    end

endmodule

// File: tb/tb_edge_row_reader.sv
// Scoreboard bench for edge_row_reader with a 1-cycle-ready cache model.
// Build with EDGE_READER_SKIP_SELF_EN to exercise the self-column skip.
module tb_edge_row_reader;

    localparam int IW = 5;
    localparam int VW = 16;
    localparam int CW = IW + 1;

`ifdef EDGE_READER_SKIP_SELF_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct packed {
        logic [IW-1:0] to;
        logic [VW-1:0] w;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [IW-1:0] node;
    logic [CW-1:0] num_nodes;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_to_node;
    logic [VW-1:0] out_weight;
    logic [IW-1:0] cache_from_node;
    logic [IW-1:0] cache_to_node;
    logic          cache_read_enable;
    logic          cache_ready;
    logic [VW-1:0] cache_edge_value;

    logic [VW-1:0] mem [0:31];
    logic [IW-1:0] exp_from;
    logic [IW-1:0] last_addr;
    int            read_count = 0;
    int            bad_from = 0;
    int            done_count = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    exp_t          sb[$];
    exp_t          got;

    always #5 clock = ~clock;

    edge_row_reader #(
        .MAX_NODES(32),
        .INDEX_WIDTH(IW),
        .VALUE_WIDTH(VW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .node(node),
        .num_nodes(num_nodes),
        .busy(busy),
        .done(done),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_to_node(out_to_node),
        .out_weight(out_weight),
        .cache_from_node(cache_from_node),
        .cache_to_node(cache_to_node),
        .cache_read_enable(cache_read_enable),
        .cache_ready(cache_ready),
        .cache_edge_value(cache_edge_value)
    );

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            cache_ready      <= 1'b0;
            cache_edge_value <= '0;
        end else begin
            cache_ready      <= cache_read_enable;
            cache_edge_value <= mem[cache_to_node];
        end
    end

    always @(posedge clock) begin
        if (!reset && cache_read_enable) begin
            read_count = read_count + 1;
            last_addr  = cache_to_node;
            if (cache_from_node != exp_from) bad_from = bad_from + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (done) done_count = done_count + 1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp = n_cmp + 1;
                n_err = n_err + 1;
                $display("FAIL unexpected edge: got (%0d,0x%0h), expected none",
                         out_to_node, out_weight);
            end else begin
                got = sb.pop_front();
                check("edge to_node", 32'(out_to_node), 32'(got.to));
                check("edge weight", 32'(out_weight), 32'(got.w));
            end
        end
    end

    task automatic expect_edge(input logic [IW-1:0] t, input logic [VW-1:0] w);
        exp_t e;
        e.to = t;
        e.w  = w;
        sb.push_back(e);
    endtask

    task automatic fill(input logic [VW-1:0] w);
        for (int i = 0; i < 32; i++) mem[i] = w;
    endtask

    task automatic pulse_start(input logic [IW-1:0] nd, input logic [CW-1:0] nn);
        @(posedge clock);
        #1;
        node      = nd;
        num_nodes = nn;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic finish_row(input string tag, input int r0, input int d0,
                              input int exp_reads);
        wait_done({tag, " done seen"}, 300);
        repeat (3) @(negedge clock);
        check({tag, " reads"}, 32'(read_count - r0), 32'(exp_reads));
        check({tag, " done pulses"}, 32'(done_count - d0), 32'd1);
        check({tag, " queue drained"}, 32'(sb.size()), 32'd0);
        check({tag, " from_node"}, 32'(bad_from), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  r0;
        int  d0;
        int  r1;
        bit  found;
        int  seen;

        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        node      = '0;
        num_nodes = '0;
        exp_from  = '0;
        fill(16'hFFFF);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset ctrl", 32'({busy, done, out_valid, cache_read_enable}), 32'd0);
        check("reset data", {1'b0, out_to_node, out_weight, cache_from_node,
                             cache_to_node}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Row 3: present at 0 and 2, plus first-edge latency.
        fill(16'hFFFF);
        mem[0] = 16'd5;
        mem[2] = 16'd7;
        exp_from = 5'd3;
        r0 = read_count;
        d0 = done_count;
        expect_edge(5'd0, 16'd5);
        expect_edge(5'd2, 16'd7);
        pulse_start(5'd3, 6'd4);
        check("t1 issue read_enable", 32'(cache_read_enable), 32'd1);
        check("t1 busy after accept", 32'(busy), 32'd1);
        @(posedge clock);
        #1 check("t1 valid early", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1 check("t1 valid latency", 32'(out_valid), 32'd1);
        finish_row("t1", r0, d0, SKIP ? 3 : 4);

        // Same row with consumer stalled on the first edge.
        r0 = read_count;
        d0 = done_count;
        expect_edge(5'd0, 16'd5);
        expect_edge(5'd2, 16'd7);
        out_ready = 1'b0;
        pulse_start(5'd3, 6'd4);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("t2 valid seen", 32'(found), 32'd1);
        r1 = read_count;
        for (int k = 0; k < 5; k++) begin
            check("t2 hold valid", 32'(out_valid), 32'd1);
            check("t2 hold to_node", 32'(out_to_node), 32'd0);
            check("t2 hold weight", 32'(out_weight), 32'd5);
            if (k < 4) @(negedge clock);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        check("t2 no read while stalled", 32'(read_count - r1), 32'd0);
        finish_row("t2", r0, d0, SKIP ? 3 : 4);

        // Empty row.
        r0 = read_count;
        d0 = done_count;
        exp_from = 5'd2;
        pulse_start(5'd2, 6'd0);
        check("t3 done next cycle", 32'(done), 32'd1);
        check("t3 no read_enable", 32'(cache_read_enable), 32'd0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (out_valid || cache_read_enable) seen = seen + 1;
        end
        check("t3 done one cycle", 32'(done), 32'd0);
        check("t3 quiet", 32'(seen), 32'd0);
        check("t3 reads", 32'(read_count - r0), 32'd0);
        check("t3 done pulses", 32'(done_count - d0), 32'd1);

        // num_nodes above MAX_NODES clamps to 32 columns.
        fill(16'hFFFF);
        mem[31] = 16'h0031;
        exp_from = 5'd4;
        r0 = read_count;
        d0 = done_count;
        expect_edge(5'd31, 16'h0031);
        pulse_start(5'd4, 6'd40);
        finish_row("t4", r0, d0, SKIP ? 31 : 32);
        check("t4 last addr", 32'(last_addr), 32'd31);

        // Reset while waiting on column 2.
        fill(16'hFFFF);
        mem[2] = 16'd8;
        exp_from = 5'd5;
        d0 = done_count;
        pulse_start(5'd5, 6'd4);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (cache_read_enable && cache_to_node == 5'd2) begin
                found = 1'b1;
                break;
            end
        end
        check("t5 reached col2", 32'(found), 32'd1);
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("t5 ctrl cleared", 32'({busy, done, out_valid, cache_read_enable}), 32'd0);
        check("t5 data cleared", {1'b0, out_to_node, out_weight, cache_from_node,
                                  cache_to_node}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (4) @(negedge clock);
        check("t5 no done", 32'(done_count - d0), 32'd0);
        check("t5 no stray edges", 32'(sb.size()), 32'd0);

        fill(16'hFFFF);
        mem[0] = 16'd1;
        mem[1] = 16'd2;
        mem[2] = 16'd3;
        exp_from = 5'd6;
        r0 = read_count;
        d0 = done_count;
        expect_edge(5'd0, 16'd1);
        expect_edge(5'd1, 16'd2);
        expect_edge(5'd2, 16'd3);
        pulse_start(5'd6, 6'd3);
        finish_row("t5 rerun", r0, d0, 3);

        // Self column, with a start pulse while busy.
        fill(16'd9);
        exp_from = 5'd1;
        r0 = read_count;
        d0 = done_count;
        expect_edge(5'd0, 16'd9);
        if (!SKIP) expect_edge(5'd1, 16'd9);
        expect_edge(5'd2, 16'd9);
        pulse_start(5'd1, 6'd3);
        @(posedge clock);
        #1;
        node      = 5'd7;
        num_nodes = 6'd5;
        start     = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        finish_row("t6", r0, d0, SKIP ? 2 : 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
